// File: rtl/rev_dp_pkg.sv
// Shared types and op helpers for the reversible datapath.
package rev_dp_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_XOR  = 3'b011,
    OP_SWAP = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_XLD  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  function automatic op_t inv_op(input op_t op);
    case (op)
      OP_ADD:  inv_op = OP_SUB;
      OP_SUB:  inv_op = OP_ADD;
      OP_ROL:  inv_op = OP_ROR;
      OP_ROR:  inv_op = OP_ROL;
      default: inv_op = op;
    endcase
  endfunction

  // Two-operand ops that would destroy information when Rd and Rs alias.
  function automatic logic is_illegal(input op_t op, input logic same_reg);
    is_illegal = same_reg &&
                 (op == OP_ADD || op == OP_SUB || op == OP_XOR || op == OP_SWAP);
  endfunction

endpackage

// File: rtl/rev_alu.sv
// Combinational ALU for the reversible op set; SWAP returns both operands exchanged.
module rev_alu
  import rev_dp_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_b,
  output logic             ovf
);

  op_t op_e;
  assign op_e = op_t'(op);

  always_comb begin
    result   = a;
    result_b = b;
    ovf      = 1'b0;
    case (op_e)
      OP_ADD: begin
        result = a + b + WIDTH'(cin);
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = a - b - WIDTH'(cin);
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR: result = a ^ b;
      OP_SWAP: begin
        result   = b;
        result_b = a;
      end
      OP_ROL:  result = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  result = {a[0], a[WIDTH-1:1]};
      OP_XLD:  result = a ^ din;
      default: result = a;
    endcase
  end

endmodule

// File: rtl/rev_datapath.sv
// Reversible register-file datapath with PC: IDLE -> EXEC -> WB per op, DIR runs ops and PC backwards.
module rev_datapath
  import rev_dp_pkg::*;
#(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned NREG   = 4,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    OP_VALID,
  output logic                    OP_READY,
  input  logic [2:0]              OP,
  input  logic                    DIR,
  input  logic [$clog2(NREG)-1:0] RD,
  input  logic [$clog2(NREG)-1:0] RS,
  input  logic                    CIN,
  input  logic [WIDTH-1:0]        DATA_IN,
  input  logic                    WE_PC,
  input  logic [ADDR_W-1:0]       PC_IN,
  output logic [ADDR_W-1:0]       ADDR_OUT,
  output logic [WIDTH-1:0]        DATA_OUT,
  output logic                    OVF,
  output logic                    DONE,
  output logic                    ERR
);

  state_t                    state_q, state_d;
  op_t                       op_q;
  logic                      dir_q, cin_q, we_pc_q;
  logic [$clog2(NREG)-1:0]   rd_q, rs_q;
  logic [WIDTH-1:0]          din_q;
  logic [ADDR_W-1:0]         pc_in_q, pc_q;
  logic [WIDTH-1:0]          regs [NREG];
  logic [WIDTH-1:0]          alu_res, alu_res_b, res_q, res_b_q;
  logic                      alu_ovf, ovf_op_q, ill_q;
  logic [WIDTH-1:0]          data_out_q;
  logic                      ovf_q, done_q, err_q;

  assign OP_READY = (state_q == IDLE) && !RESET;
  assign ADDR_OUT = pc_q;
  assign DATA_OUT = data_out_q;
  assign OVF      = ovf_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

  rev_alu #(.WIDTH(WIDTH)) u_alu (
    .op       (op_q),
    .a        (regs[rd_q]),
    .b        (regs[rs_q]),
    .cin      (cin_q),
    .din      (din_q),
    .result   (alu_res),
    .result_b (alu_res_b),
    .ovf      (alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (OP_VALID) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      op_q       <= OP_NOP;
      dir_q      <= 1'b0;
      cin_q      <= 1'b0;
      we_pc_q    <= 1'b0;
      rd_q       <= '0;
      rs_q       <= '0;
      din_q      <= '0;
      pc_in_q    <= '0;
      pc_q       <= '0;
      res_q      <= '0;
      res_b_q    <= '0;
      ovf_op_q   <= 1'b0;
      ill_q      <= 1'b0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (OP_VALID) begin
          // The reversed op is resolved once here so EXEC/WB only see the effective op.
          op_q    <= DIR ? inv_op(op_t'(OP)) : op_t'(OP);
          dir_q   <= DIR;
          cin_q   <= CIN;
          we_pc_q <= WE_PC;
          rd_q    <= RD;
          rs_q    <= RS;
          din_q   <= DATA_IN;
          pc_in_q <= PC_IN;
        end
        EXEC: begin
          res_q    <= alu_res;
          res_b_q  <= alu_res_b;
          ovf_op_q <= alu_ovf;
          ill_q    <= is_illegal(op_q, rd_q == rs_q);
        end
        WB: begin
          if (!ill_q && op_q != OP_NOP) begin
            regs[rd_q] <= res_q;
            if (op_q == OP_SWAP) regs[rs_q] <= res_b_q;
            data_out_q <= res_q;
            if (op_q == OP_ADD || op_q == OP_SUB) ovf_q <= ovf_q ^ ovf_op_q;
          end
          if (we_pc_q)    pc_q <= pc_in_q;
          else if (dir_q) pc_q <= pc_q - ADDR_W'(1);
          else            pc_q <= pc_q + ADDR_W'(1);
          done_q <= 1'b1;
          err_q  <= ill_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rev_datapath.sv
// Directed scoreboard bench for rev_datapath: issued ops queue hand-computed results, a monitor checks each DONE.
module tb_rev_datapath;
  import rev_dp_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, OP_VALID, OP_READY;
  logic [2:0]  OP;
  logic        DIR, CIN, WE_PC;
  logic [1:0]  RD, RS;
  logic [11:0] DATA_IN, PC_IN, ADDR_OUT, DATA_OUT;
  logic        OVF, DONE, ERR;

  always #5 CLK = ~CLK;

  rev_datapath #(.WIDTH(12), .NREG(4), .ADDR_W(12)) dut (
    .CLK(CLK), .RESET(RESET), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
    .OP(OP), .DIR(DIR), .RD(RD), .RS(RS), .CIN(CIN), .DATA_IN(DATA_IN),
    .WE_PC(WE_PC), .PC_IN(PC_IN), .ADDR_OUT(ADDR_OUT), .DATA_OUT(DATA_OUT),
    .OVF(OVF), .DONE(DONE), .ERR(ERR)
  );

  typedef struct {
    string       nm;
    logic [11:0] data;
    logic        ovf;
    logic        err;
    logic [11:0] pc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push_exp(input string nm, input logic [11:0] d, input logic o,
                          input logic e, input logic [11:0] p);
    exp_t x;
    x.nm = nm; x.data = d; x.ovf = o; x.err = e; x.pc = p;
    sb.push_back(x);
  endtask

  always @(negedge CLK) begin
    if (!RESET && DONE) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got DONE=1 at pc %0h, expected no completion", ADDR_OUT);
      end else begin
        e = sb.pop_front();
        check({e.nm, ".data"}, 32'(DATA_OUT), 32'(e.data));
        check({e.nm, ".ovf"},  32'(OVF),      32'(e.ovf));
        check({e.nm, ".err"},  32'(ERR),      32'(e.err));
        check({e.nm, ".pc"},   32'(ADDR_OUT), 32'(e.pc));
      end
    end
  end

  task automatic wait_ready(input string nm);
    int unsigned k = 0;
    @(negedge CLK);
    while (!OP_READY && k < 20) begin
      @(negedge CLK);
      k++;
    end
    if (!OP_READY) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s.ready_timeout: got OP_READY=0 after %0d cycles, expected 1", nm, k);
    end
  endtask

  task automatic issue(input string nm, input op_t op, input logic dir,
                       input logic [1:0] rd, input logic [1:0] rs, input logic cin,
                       input logic [11:0] din, input logic we, input logic [11:0] pcin,
                       input logic [11:0] e_data, input logic e_ovf, input logic e_err,
                       input logic [11:0] e_pc);
    wait_ready(nm);
    OP = op; DIR = dir; RD = rd; RS = rs; CIN = cin;
    DATA_IN = din; WE_PC = we; PC_IN = pcin; OP_VALID = 1'b1;
    push_exp(nm, e_data, e_ovf, e_err, e_pc);
    @(posedge CLK);
    #1;
    // Scramble inputs after capture so a design sampling late would be caught.
    OP_VALID = 1'b0; OP = ~OP; DIR = ~DIR; RD = ~RD; RS = ~RS;
    DATA_IN = ~DATA_IN; WE_PC = ~WE_PC; PC_IN = ~PC_IN;
    @(negedge CLK);
    check({nm, ".rdy_exec"}, 32'(OP_READY), 32'd0);
    @(negedge CLK);
    check({nm, ".rdy_wb"}, 32'(OP_READY), 32'd0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, ".addr"}, 32'(ADDR_OUT), 32'd0);
    check({nm, ".data"}, 32'(DATA_OUT), 32'd0);
    check({nm, ".ovf"},  32'(OVF),      32'd0);
    check({nm, ".done"}, 32'(DONE),     32'd0);
    check({nm, ".err"},  32'(ERR),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish earlier");
    $fatal(1, "watchdog expired");
  end

  logic [11:0] stream_exp [10];

  initial begin
    int unsigned k;
    RESET = 1'b1; OP_VALID = 1'b0; OP = 3'b000; DIR = 1'b0; RD = '0; RS = '0;
    CIN = 1'b0; DATA_IN = '0; WE_PC = 1'b0; PC_IN = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset.ready", 32'(OP_READY), 32'd0);
    check_zero("reset");
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("reset.ready_after", 32'(OP_READY), 32'd1);

    //     name        op       dir rd rs cin din     we pcin    data    ovf err pc
    issue("xld_r0",    OP_XLD,  0, 0, 0, 0, 12'h007, 0, 12'h000, 12'h007, 0, 0, 12'h001);
    issue("xld_r1",    OP_XLD,  0, 1, 0, 0, 12'h019, 0, 12'h000, 12'h019, 0, 0, 12'h002);
    issue("add_fwd",   OP_ADD,  0, 0, 1, 0, 12'h000, 0, 12'h000, 12'h020, 0, 0, 12'h003);
    issue("add_rev",   OP_ADD,  1, 0, 1, 0, 12'h000, 0, 12'h000, 12'h007, 0, 0, 12'h002);
    issue("set_7ff",   OP_XLD,  0, 0, 0, 0, 12'h7F8, 0, 12'h000, 12'h7FF, 0, 0, 12'h003);
    issue("set_001",   OP_XLD,  0, 1, 0, 0, 12'h018, 0, 12'h000, 12'h001, 0, 0, 12'h004);
    issue("add_ovf",   OP_ADD,  0, 0, 1, 0, 12'h000, 0, 12'h000, 12'h800, 1, 0, 12'h005);
    issue("set_r2",    OP_XLD,  0, 2, 0, 0, 12'h0C3, 0, 12'h000, 12'h0C3, 1, 0, 12'h006);
    issue("add_ill",   OP_ADD,  0, 2, 2, 0, 12'h000, 0, 12'h000, 12'h0C3, 1, 1, 12'h007);
    issue("read_r2",   OP_XLD,  0, 2, 0, 0, 12'h000, 0, 12'h000, 12'h0C3, 1, 0, 12'h008);
    issue("add_ovf_r", OP_ADD,  1, 0, 1, 0, 12'h000, 0, 12'h000, 12'h7FF, 0, 0, 12'h007);
    issue("set_00a",   OP_XLD,  0, 0, 0, 0, 12'h7F5, 0, 12'h000, 12'h00A, 0, 0, 12'h008);
    issue("set_0f0",   OP_XLD,  0, 1, 0, 0, 12'h0F1, 0, 12'h000, 12'h0F0, 0, 0, 12'h009);
    issue("swap",      OP_SWAP, 0, 0, 1, 0, 12'h000, 0, 12'h000, 12'h0F0, 0, 0, 12'h00A);
    issue("read_r1a",  OP_XLD,  0, 1, 0, 0, 12'h000, 0, 12'h000, 12'h00A, 0, 0, 12'h00B);
    issue("swap_rev",  OP_SWAP, 1, 0, 1, 0, 12'h000, 0, 12'h000, 12'h00A, 0, 0, 12'h00A);
    issue("read_r1b",  OP_XLD,  0, 1, 0, 0, 12'h000, 0, 12'h000, 12'h0F0, 0, 0, 12'h00B);
    issue("set_801",   OP_XLD,  0, 3, 0, 0, 12'h801, 0, 12'h000, 12'h801, 0, 0, 12'h00C);
    issue("rol",       OP_ROL,  0, 3, 0, 0, 12'h000, 0, 12'h000, 12'h003, 0, 0, 12'h00D);
    issue("rol_rev",   OP_ROL,  1, 3, 0, 0, 12'h000, 0, 12'h000, 12'h801, 0, 0, 12'h00C);
    issue("ror",       OP_ROR,  0, 3, 0, 0, 12'h000, 0, 12'h000, 12'hC00, 0, 0, 12'h00D);
    issue("ror_rev",   OP_ROR,  1, 3, 0, 0, 12'h000, 0, 12'h000, 12'h801, 0, 0, 12'h00C);
    issue("sub_cin",   OP_SUB,  0, 0, 1, 1, 12'h000, 0, 12'h000, 12'hF19, 0, 0, 12'h00D);
    issue("sub_rev",   OP_SUB,  1, 0, 1, 1, 12'h000, 0, 12'h000, 12'h00A, 0, 0, 12'h00C);
    issue("xor",       OP_XOR,  0, 0, 1, 0, 12'h000, 0, 12'h000, 12'h0FA, 0, 0, 12'h00D);
    issue("xor_rev",   OP_XOR,  1, 0, 1, 0, 12'h000, 0, 12'h000, 12'h00A, 0, 0, 12'h00C);
    issue("nop",       OP_NOP,  0, 0, 1, 0, 12'h000, 0, 12'h000, 12'h00A, 0, 0, 12'h00D);
    issue("pc_load0",  OP_NOP,  0, 0, 0, 0, 12'h000, 1, 12'h000, 12'h00A, 0, 0, 12'h000);
    issue("pc_wrap_dn",OP_NOP,  1, 0, 0, 0, 12'h000, 0, 12'h000, 12'h00A, 0, 0, 12'hFFF);
    issue("pc_wrap_up",OP_NOP,  0, 0, 0, 0, 12'h000, 0, 12'h000, 12'h000 | 12'h00A, 0, 0, 12'h000);
    issue("pc_load",   OP_XLD,  0, 0, 0, 0, 12'h000, 1, 12'h123, 12'h00A, 0, 0, 12'h123);

    // Abort an ADD in EXEC; nothing is queued, so any DONE is flagged by the monitor.
    wait_ready("abort");
    OP = OP_ADD; DIR = 1'b0; RD = 2'd0; RS = 2'd1; CIN = 1'b0; WE_PC = 1'b0; OP_VALID = 1'b1;
    @(posedge CLK);
    #1 OP_VALID = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    check("abort.ready_in_reset", 32'(OP_READY), 32'd0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check_zero("abort");
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("abort.ready_after", 32'(OP_READY), 32'd1);
    repeat (4) begin
      @(negedge CLK);
      check("abort.no_done", 32'(DONE), 32'd0);
    end

    // Streaming: OP_VALID held high, XLD R3 ^= 1..10 from zeroed state.
    stream_exp[0] = 12'h001; stream_exp[1] = 12'h003; stream_exp[2] = 12'h000;
    stream_exp[3] = 12'h004; stream_exp[4] = 12'h001; stream_exp[5] = 12'h007;
    stream_exp[6] = 12'h000; stream_exp[7] = 12'h008; stream_exp[8] = 12'h001;
    stream_exp[9] = 12'h00B;
    @(posedge CLK);
    #1;
    OP = OP_XLD; DIR = 1'b0; RD = 2'd3; RS = 2'd0; WE_PC = 1'b0; DATA_IN = 12'd1;
    OP_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      k = 0;
      do begin
        @(negedge CLK);
        k++;
      end while (!OP_READY && k < 10);
      if (i > 0) check($sformatf("stream%0d.spacing", i), 32'(k), 32'd3);
      push_exp($sformatf("stream%0d", i), stream_exp[i], 1'b0, 1'b0, 12'(i + 1));
      @(posedge CLK);
      #1 DATA_IN = 12'(i + 2);
    end
    OP_VALID = 1'b0;

    k = 0;
    while (sb.size() != 0 && k < 12) begin
      @(negedge CLK);
      k++;
    end
    @(negedge CLK);
    check("drain.pending", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
